// File: rtl/mmio_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : mmio_pkg                                                |
// | Purpose : Shared MMIO offsets, status bit positions, FIFO depth   |
// |           default and the status-word packing helper for the     |
// |           UART MMIO controller.                                  |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
package mmio_pkg;

  localparam int FIFO_DEPTH_DEFAULT = 8;

  // Word-aligned offsets inside the 0x8000_00xx window
  localparam logic [7:0] ADDR_STATUS  = 8'h00;
  localparam logic [7:0] ADDR_RX_DATA = 8'h04;
  localparam logic [7:0] ADDR_TX_DATA = 8'h08;
  localparam logic [7:0] ADDR_CYCLE   = 8'h10;
  localparam logic [7:0] ADDR_INSTRET = 8'h14;
  localparam logic [7:0] ADDR_CNT_CLR = 8'h18;

  // Status register bit positions
  localparam int STAT_TX_NOT_FULL  = 0;
  localparam int STAT_RX_NOT_EMPTY = 1;
  localparam int STAT_TX_OVERFLOW  = 2;

  function automatic logic [31:0] pack_status(input logic tx_overflow,
                                              input logic rx_not_empty,
                                              input logic tx_not_full);
    logic [31:0] s;
    s                    = '0;
    s[STAT_TX_OVERFLOW]  = tx_overflow;
    s[STAT_RX_NOT_EMPTY] = rx_not_empty;
    s[STAT_TX_NOT_FULL]  = tx_not_full;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : byte_fifo                                               |
// | Purpose : Synchronous count-based byte FIFO. A push while full is |
// |           accepted only when a pop happens in the same cycle; a   |
// |           pop while empty is ignored.                             |
// | Ports   : clk, rst (async, active high), push/wdata, pop/rdata    |
// |           (rdata is the head byte), full, empty.                  |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_COUNT);
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are log2(DEPTH) wide, so the increment wraps modulo DEPTH
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers/count
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/uart_mmio_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : uart_mmio_ctrl                                          |
// | Purpose : MMIO front end for a UART: TX/RX byte FIFOs, status     |
// |           word with sticky TX overflow, free-running cycle and    |
// |           retired-instruction counters.                           |
// | Ports   : clk, rst (async, active high)                           |
// |           mmio_en/we/addr/wdata -> mmio_rdata (registered load)   |
// |           inst_retired : instruction-retire pulse                 |
// |           tx_data/tx_valid/tx_ready : byte stream to transmitter  |
// |           rx_data/rx_valid/rx_ready : byte stream from receiver   |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module uart_mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mmio_en,
  input  logic        mmio_we,
  input  logic [7:0]  mmio_addr,
  input  logic [7:0]  mmio_wdata,
  output logic [31:0] mmio_rdata,
  input  logic        inst_retired,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  logic        is_load, is_store;
  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  rx_head;
  logic        cnt_clr;

  logic [31:0] rdata_q, rdata_d;
  logic        tx_overflow_q, tx_overflow_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] inst_cnt_q, inst_cnt_d;

  assign is_load  = mmio_en & ~mmio_we;
  assign is_store = mmio_en & mmio_we;

  assign tx_valid = ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  // The FIFO itself decides whether a push to a full FIFO survives
  assign tx_push  = is_store & (mmio_addr == ADDR_TX_DATA);

  assign rx_ready = ~rx_full;
  assign rx_push  = rx_valid & rx_ready;
  assign rx_pop   = is_load & (mmio_addr == ADDR_RX_DATA) & ~rx_empty;

  assign cnt_clr  = is_store & (mmio_addr == ADDR_CNT_CLR);

  assign mmio_rdata = rdata_q;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .wdata (mmio_wdata),
    .pop   (tx_pop),
    .rdata (tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .wdata (rx_data),
    .pop   (rx_pop),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_comb begin
    rdata_d = rdata_q;
    if (is_load) begin
      case (mmio_addr)
        ADDR_STATUS:  rdata_d = pack_status(tx_overflow_q, ~rx_empty, ~tx_full);
        ADDR_RX_DATA: rdata_d = rx_empty ? 32'h0 : {24'h0, rx_head};
        ADDR_CYCLE:   rdata_d = cycle_cnt_q;
        ADDR_INSTRET: rdata_d = inst_cnt_q;
        default:      rdata_d = 32'h0;
      endcase
    end
  end

  always_comb begin
    tx_overflow_d = tx_overflow_q;
    // Dropped store: full and the head is not leaving this cycle
    if (tx_push & tx_full & ~tx_pop) tx_overflow_d = 1'b1;
    if (cnt_clr)                     tx_overflow_d = 1'b0;
  end

  always_comb begin
    cycle_cnt_d = cycle_cnt_q + 32'd1;
    inst_cnt_d  = inst_cnt_q + {31'd0, inst_retired};
    if (cnt_clr) begin
      cycle_cnt_d = 32'h0;
      inst_cnt_d  = 32'h0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q       <= 32'h0;
      tx_overflow_q <= 1'b0;
      cycle_cnt_q   <= 32'h0;
      inst_cnt_q    <= 32'h0;
    end else begin
      rdata_q       <= rdata_d;
      tx_overflow_q <= tx_overflow_d;
      cycle_cnt_q   <= cycle_cnt_d;
      inst_cnt_q    <= inst_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_mmio_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_uart_mmio_ctrl                                       |
// | Purpose : Directed self-checking bench for uart_mmio_ctrl. Inputs |
// |           change and outputs are sampled on the falling edge.    |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module tb_uart_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mmio_en = 1'b0;
  logic        mmio_we = 1'b0;
  logic [7:0]  mmio_addr = 8'h0;
  logic [7:0]  mmio_wdata = 8'h0;
  logic [31:0] mmio_rdata;
  logic        inst_retired = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_mmio_ctrl #(.FIFO_DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .mmio_en      (mmio_en),
    .mmio_we      (mmio_we),
    .mmio_addr    (mmio_addr),
    .mmio_wdata   (mmio_wdata),
    .mmio_rdata   (mmio_rdata),
    .inst_retired (inst_retired),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready)
  );

  // One-cycle load; returns the registered response seen on the next falling edge
  task automatic mmio_load(input logic [7:0] addr, output logic [31:0] data);
    @(negedge clk);
    mmio_en = 1'b1; mmio_we = 1'b0; mmio_addr = addr;
    @(negedge clk);
    mmio_en = 1'b0;
    data = mmio_rdata;
  endtask

  task automatic mmio_store(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    mmio_en = 1'b1; mmio_we = 1'b1; mmio_addr = addr; mmio_wdata = data;
    @(negedge clk);
    mmio_en = 1'b0; mmio_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #2;
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid got %0b want 0", tx_valid); end
    n_vec++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL reset_rx_ready got %0b want 1", rx_ready); end
    n_vec++; if (mmio_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", mmio_rdata); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    mmio_load(8'h00, d);
    n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL reset_status got %h want 00000001", d); end
    mmio_load(8'h0C, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL unmapped_load got %h want 0", d); end
  endtask

  task automatic test_tx_path();
    logic [31:0] d;
    tx_ready = 1'b0;
    mmio_store(8'h08, 8'h41);
    mmio_store(8'h08, 8'h42);
    // Store to a read-only offset must not disturb anything
    mmio_store(8'h00, 8'hFF);
    n_vec++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin n_err++; $display("FAIL tx_head0 got v=%0b d=%h want v=1 d=41", tx_valid, tx_data); end
    tx_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (tx_valid !== 1'b1 || tx_data !== 8'h42) begin n_err++; $display("FAIL tx_head1 got v=%0b d=%h want v=1 d=42", tx_valid, tx_data); end
    @(negedge clk);
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL tx_drained got v=%0b want 0", tx_valid); end
    tx_ready = 1'b0;
    mmio_load(8'h00, d);
    n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL tx_path_status got %h want 00000001", d); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] d;
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) mmio_store(8'h08, 8'(8'h60 + i));
    mmio_load(8'h00, d);
    n_vec++; if (d !== 32'h4) begin n_err++; $display("FAIL ovf_status got %h want 00000004", d); end
    mmio_store(8'h18, 8'h00);
    mmio_load(8'h00, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL ovf_cleared got %h want 00000000", d); end
    @(negedge clk);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h60 + i)) begin
        n_err++; $display("FAIL ovf_drain%0d got v=%0b d=%h want v=1 d=%h", i, tx_valid, tx_data, 8'(8'h60 + i));
      end
      @(negedge clk);
    end
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL ovf_ninth_dropped got v=%0b want 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_rx_backpressure();
    logic [31:0] d;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_valid = 1'b1; rx_data = 8'(8'h10 + i);
      @(negedge clk);
    end
    // Extra offered byte must be refused while full
    rx_data = 8'h99;
    n_vec++; if (rx_ready !== 1'b0) begin n_err++; $display("FAIL rx_full_ready got %0b want 0", rx_ready); end
    @(negedge clk);
    rx_valid = 1'b0;
    mmio_load(8'h00, d);
    n_vec++; if (d !== 32'h3) begin n_err++; $display("FAIL rx_full_status got %h want 00000003", d); end
    for (int i = 0; i < 8; i++) begin
      mmio_load(8'h04, d);
      n_vec++;
      if (d !== {24'h0, 8'(8'h10 + i)}) begin n_err++; $display("FAIL rx_pop%0d got %h want %h", i, d, 8'(8'h10 + i)); end
    end
    mmio_load(8'h04, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rx_empty_load got %h want 0", d); end
    n_vec++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL rx_ready_after got %0b want 1", rx_ready); end
  endtask

  task automatic test_counters();
    logic [31:0] d;
    mmio_store(8'h18, 8'h00);
    for (int i = 0; i < 100; i++) begin
      inst_retired = ((i % 5) < 2);
      @(negedge clk);
    end
    inst_retired = 1'b0;
    mmio_load(8'h14, d);
    n_vec++; if (d !== 32'd40) begin n_err++; $display("FAIL instret_40 got %0d want 40", d); end
    mmio_load(8'h10, d);
    n_vec++; if (d < 32'd100 || d > 32'd120) begin n_err++; $display("FAIL cycle_ge100 got %0d want 100..120", d); end
    // Clear wins over a same-cycle retire pulse
    @(negedge clk);
    mmio_en = 1'b1; mmio_we = 1'b1; mmio_addr = 8'h18; inst_retired = 1'b1;
    @(negedge clk);
    mmio_en = 1'b0; mmio_we = 1'b0; inst_retired = 1'b0;
    mmio_load(8'h14, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL clr_priority got %0d want 0", d); end
    // Preset the instruction counter to all ones and step it once
    @(negedge clk);
    force dut.inst_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.inst_cnt_q;
    mmio_load(8'h14, d);
    n_vec++; if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL instret_max got %h want ffffffff", d); end
    @(negedge clk);
    inst_retired = 1'b1;
    @(negedge clk);
    inst_retired = 1'b0;
    mmio_load(8'h14, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL instret_wrap got %h want 0", d); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) mmio_store(8'h08, 8'(8'h80 + i));
    @(negedge clk);
    tx_ready = 1'b1;
    mmio_en = 1'b1; mmio_we = 1'b1; mmio_addr = 8'h08; mmio_wdata = 8'h88;
    @(negedge clk);
    tx_ready = 1'b0; mmio_en = 1'b0; mmio_we = 1'b0;
    mmio_load(8'h00, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL simul_status got %h want 00000000", d); end
    @(negedge clk);
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      n_vec++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h80 + i)) begin
        n_err++; $display("FAIL simul_drain%0d got v=%0b d=%h want v=1 d=%h", i, tx_valid, tx_data, 8'(8'h80 + i));
      end
      @(negedge clk);
    end
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL simul_empty got v=%0b want 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    logic [31:0] d;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) mmio_store(8'h08, 8'(8'hA0 + i));
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_valid = 1'b1; rx_data = 8'(8'hB0 + i);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    mmio_load(8'h00, d);
    n_vec++; if (d !== 32'h3) begin n_err++; $display("FAIL mid_pre_status got %h want 00000003", d); end
    // Launch an RX load and hit reset before its capturing edge
    mmio_en = 1'b1; mmio_we = 1'b0; mmio_addr = 8'h04;
    #2 rst = 1'b1;
    #1;
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL mid_tx_valid got %0b want 0", tx_valid); end
    n_vec++; if (mmio_rdata !== 32'h0) begin n_err++; $display("FAIL mid_rdata got %h want 0", mmio_rdata); end
    n_vec++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL mid_rx_ready got %0b want 1", rx_ready); end
    @(negedge clk);
    mmio_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (mmio_rdata !== 32'h0) begin n_err++; $display("FAIL mid_post_rdata got %h want 0", mmio_rdata); end
    mmio_load(8'h00, d);
    n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL mid_status got %h want 00000001", d); end
    mmio_load(8'h04, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL mid_rx_empty got %h want 0", d); end
  endtask

  initial begin
    test_reset();
    test_tx_path();
    test_tx_overflow();
    test_rx_backpressure();
    test_counters();
    test_simultaneous();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_mmio_ctrl.md
UART_MMIO_CTRL -- requirements
Module: uart_mmio_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning the entry count of each of the TX and RX byte FIFOs (power of two, 2..64).
REQ-002 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port mmio_en, input, 1, CPU MMIO access strobe for one cycle.
REQ-005 SHALL have port mmio_we, input, 1, 1 = store, 0 = load; qualified by mmio_en.
REQ-006 SHALL have port mmio_addr, input, 8, word-aligned offset within the 0x8000_00xx window.
REQ-007 SHALL have port mmio_wdata, input, 8, store byte (rs2[7:0]).
REQ-008 SHALL have port mmio_rdata, output, 32, registered load data.
REQ-009 SHALL have port inst_retired, input, 1, one pulse per retired instruction.
REQ-010 SHALL have port tx_data, output, 8, byte to UART transmitter.
REQ-011 SHALL have port tx_valid, output, 1, TX byte offered.
REQ-012 SHALL have port tx_ready, input, 1, UART transmitter accepts byte.
REQ-013 SHALL have port rx_data, input, 8, byte from UART receiver.
REQ-014 SHALL have port rx_valid, input, 1, received byte offered.
REQ-015 SHALL have port rx_ready, output, 1, controller accepts received byte.

Function
REQ-016 SHALL decode offsets: 0x00 status (R), 0x04 RX data (R), 0x08 TX data (W), 0x10 cycle counter (R), 0x14 instruction counter (R), 0x18 counter clear (W).
REQ-017 SHALL return status as {29'b0, tx_overflow, rx_not_empty, tx_not_full}, sampled in the request cycle.
REQ-018 SHALL drive mmio_rdata one cycle after a load (mmio_en & ~mmio_we), holding it until the next load.
REQ-019 SHALL return {24'b0, head byte} on an RX data load and pop the RX FIFO in the request cycle; an empty FIFO returns 0 with no pop.
REQ-020 SHALL return 0 for loads of unmapped offsets or write-only offsets; stores to unmapped or read-only offsets have no effect.
REQ-021 SHALL push mmio_wdata on a TX data store when TX count < FIFO_DEPTH, or when full and a TX pop occurs the same cycle.
REQ-022 SHALL drop a TX store to a full FIFO with no same-cycle pop and set sticky tx_overflow, cleared only by reset or a counter-clear store.
REQ-023 SHALL drive tx_valid = TX FIFO not empty and tx_data = head byte; pop on tx_valid & tx_ready.
REQ-024 SHALL drive rx_ready = RX count < FIFO_DEPTH; push rx_data on rx_valid & rx_ready.
REQ-025 SHALL accept simultaneous push and pop on either FIFO, leaving the count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-026 SHALL increment the 32-bit cycle counter every cycle, wrapping 0xFFFF_FFFF -> 0.
REQ-027 SHALL increment the 32-bit instruction counter on inst_retired, with the same wrap.
REQ-028 SHALL zero both counters on the cycle after a counter-clear store, with clear taking priority over any same-cycle increment.

Reset
REQ-029 SHALL, while rst is high, asynchronously clear FIFO pointers and counts, both counters, tx_overflow and mmio_rdata to 0, giving tx_valid = 0 and rx_ready = 1.
REQ-030 SHALL discard any in-flight load response when reset is asserted mid-access; the first post-reset cycle behaves as idle.

Structure
REQ-031 SHALL take offset constants, status bit indices and the default FIFO_DEPTH from a shared package, mmio_pkg.
REQ-032 SHALL instantiate one sub-module, byte_fifo (synchronous, count-based, push/pop/full/empty), twice: once for TX and once for RX.

Verification
REQ-033 SHALL cover TX path: store 0x41, 0x42 with tx_ready = 1 -> tx_data 0x41 then 0x42 on consecutive handshakes, FIFO empty afterwards.
REQ-034 SHALL cover TX overflow: tx_ready = 0, nine stores -> the ninth is dropped, status reads 0x4 (bit0 = 0, bit2 = 1); counter clear -> bit2 = 0.
REQ-035 SHALL cover RX backpressure: eight rx bytes 0x10..0x17 -> rx_ready = 0; eight RX loads return 0x10..0x17 in order; a ninth load returns 0.
REQ-036 SHALL cover counters: clear, run 100 cycles with 40 inst_retired pulses -> instruction counter reads 40 and cycle counter reads ≥ 100; preset wrap -> 0xFFFF_FFFF then 0.
REQ-037 SHALL cover simultaneous events: TX full with tx_ready = 1 plus a same-cycle store -> byte accepted, count stays 8, no overflow.
REQ-038 SHALL cover reset mid-stream: assert rst with 3 bytes in each FIFO -> tx_valid = 0, status = 0x1 and mmio_rdata = 0 immediately.
